// File: rtl/bus_pkg.sv
// Shared definitions for the bus slicer: slot numbering, op codes, cart map.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bus_pkg;

  // Four-slot frame: master address, read channel, master data, read channel.
  localparam logic [1:0] SLOT_MADDR = 2'd0;
  localparam logic [1:0] SLOT_RD0   = 2'd1;
  localparam logic [1:0] SLOT_MDATA = 2'd2;
  localparam logic [1:0] SLOT_RD1   = 2'd3;

  // Idle data bus level; replicated to the data width at the point of use
  // so the package stays independent of DW.
  localparam logic IDLE_BIT = 1'b1;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  // Cartridge decode for the 16-bit map: 0x0000-0x7FFF and 0xA000-0xBFFF.
  function automatic logic is_cart(input logic [15:0] addr);
    return (addr[15] == 1'b0) || (addr[15:13] == 3'b101);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant among NRD requesters, search starting at ptr.
// Latency: purely combinational.
// Backpressure: none; a requester simply waits until it is granted.
//   req : request vector, one bit per channel
//   ptr : channel index that has highest priority this slot
//   gnt : one-hot grant (all zero when nothing is requested)
module rr_arbiter #(
  parameter int NRD = 2,
  // Derived width of ptr; leave at its default.
  parameter int PW  = (NRD > 1) ? $clog2(NRD) : 1
) (
  input  logic [NRD-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NRD-1:0] gnt
);

  logic found;

  // Outer loop walks priority order ptr, ptr+1, ...; the inner loop keeps
  // every bit select a constant index after unrolling.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      for (int j = 0; j < NRD; j++) begin
        if (!found && req[j] && (j == ((int'(ptr) + i) % NRD))) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_slicer.sv
// Time-slices one external bus into a 4-slot frame: master addr/data slots
// and two round-robin read-channel slots. Latency: master read data 3 cycles
// after slot 0, channel read data 1 cycle after its slot. Backpressure: none;
// requestors hold r_req/r_a until r_ack, the master simply waits for slot 0.
//   clk, rst_n      : clock, synchronous active-low reset
//   ct              : current slot number
//   m_*             : master request (a/dout/wr/rd in, din/valid out)
//   r_req/r_a       : read-channel requests; r_ack/r_data/r_valid responses
//   a/dout/din/doe/wr/cale/cs : external bus
module bus_slicer
  import bus_pkg::*;
#(
  parameter int AW  = 16,
  parameter int DW  = 8,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [1:0]        ct,
  input  logic [AW-1:0]     m_a,
  input  logic [DW-1:0]     m_dout,
  input  logic              m_wr,
  input  logic              m_rd,
  output logic [DW-1:0]     m_din,
  output logic              m_valid,
  input  logic [NRD-1:0]    r_req,
  input  logic [NRD*AW-1:0] r_a,
  output logic [NRD-1:0]    r_ack,
  output logic [DW-1:0]     r_data,
  output logic [NRD-1:0]    r_valid,
  output logic [AW-1:0]     a,
  output logic [DW-1:0]     dout,
  input  logic [DW-1:0]     din,
  output logic              doe,
  output logic              wr,
  output logic              cale,
  output logic              cs
);

  localparam int PW = (NRD > 1) ? $clog2(NRD) : 1;
  localparam logic [DW-1:0] IDLE_DATA = {DW{IDLE_BIT}};

  logic [PW-1:0]  p;
  logic [AW-1:0]  lat_a;
  logic [DW-1:0]  lat_d;
  logic           lat_cart;
  op_e            lat_op;

  logic [NRD-1:0] gnt;
  logic [PW-1:0]  gidx;
  logic [PW-1:0]  p_next;
  logic [AW-1:0]  rd_addr;
  logic           rd_slot;

  assign rd_slot = (ct == SLOT_RD0) || (ct == SLOT_RD1);

  rr_arbiter #(
    .NRD (NRD),
    .PW  (PW)
  ) u_arb (
    .req (r_req),
    .ptr (p),
    .gnt (gnt)
  );

  // Grant index and granted address; both are zero when nobody is granted,
  // which gives the a=0 idle address in an empty read slot for free.
  always_comb begin
    gidx    = '0;
    rd_addr = '0;
    for (int i = 0; i < NRD; i++) begin
      if (gnt[i]) begin
        gidx = PW'(i);
      end
      rd_addr = rd_addr | (r_a[i*AW +: AW] & {AW{gnt[i]}});
    end
  end

  assign p_next = (gidx == PW'(NRD - 1)) ? '0 : gidx + PW'(1);

  // Bus drive. Reset forces idle combinationally so nothing leaks onto the
  // bus while rst_n is low, including the input-driven slot-0 address.
  always_comb begin
    a     = '0;
    dout  = IDLE_DATA;
    doe   = 1'b0;
    wr    = 1'b0;
    cale  = 1'b0;
    cs    = 1'b0;
    r_ack = '0;
    if (rst_n) begin
      case (ct)
        SLOT_MADDR: begin
          a    = m_a;
          cale = 1'b1;
        end
        SLOT_MDATA: begin
          a  = lat_a;
          cs = lat_cart && (lat_op != OP_NONE);
          if (lat_op == OP_WRITE) begin
            dout = lat_d;
            doe  = 1'b1;
            wr   = 1'b1;
          end
        end
        default: begin
          a     = rd_addr;
          r_ack = gnt;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ct       <= SLOT_MADDR;
      p        <= '0;
      lat_a    <= '0;
      lat_d    <= '0;
      lat_cart <= 1'b0;
      lat_op   <= OP_NONE;
      m_din    <= IDLE_DATA;
      r_data   <= IDLE_DATA;
      m_valid  <= 1'b0;
      r_valid  <= '0;
    end else begin
      ct      <= ct + 2'd1;
      m_valid <= 1'b0;
      r_valid <= '0;
      case (ct)
        SLOT_MADDR: begin
          lat_a    <= m_a;
          lat_d    <= m_dout;
          lat_cart <= is_cart(16'(m_a));
          // Write wins when both strobes are set.
          if (m_wr) begin
            lat_op <= OP_WRITE;
          end else if (m_rd) begin
            lat_op <= OP_READ;
          end else begin
            lat_op <= OP_NONE;
          end
        end
        SLOT_MDATA: begin
          if (lat_op == OP_READ) begin
            m_din   <= din;
            m_valid <= 1'b1;
          end
        end
        default: begin
          if (rd_slot && (|gnt)) begin
            r_data  <= din;
            r_valid <= gnt;
            p       <= p_next;
          end
        end
      endcase
    end
  end

endmodule
